// File: rtl/carpma_pkg.sv
// rtl/carpma_pkg.sv - operation encodings, sizes and retire arithmetic shared by carpma_birimi
package carpma_pkg;

   typedef enum logic [1:0] {
      ISLEM_MUL    = 2'b00,
      ISLEM_MULH   = 2'b01,
      ISLEM_MULHSU = 2'b10,
      ISLEM_MULHU  = 2'b11
   } islem_t;

   localparam int FIFO_DERINLIK   = 4;
   localparam int CARPICI_GECIKME = 3;
   localparam int ETIKET_GENISLIK = 5;
   localparam int SAYAC_GENISLIK  = $clog2(FIFO_DERINLIK + 1);
   localparam int KAYIT_GENISLIK  = ETIKET_GENISLIK + 32;

   typedef struct packed {
      logic                       gecerli;
      islem_t                     islem;
      logic [ETIKET_GENISLIK-1:0] etiket;
      logic [31:0]                islec0;
      logic [31:0]                islec1;
   } golge_t;

   // The multiplier is always signed x signed; unsigned views of the high
   // word are recovered by adding back the operand that was sign-weighted.
   function automatic logic [31:0] sonuc_hesapla(input islem_t      islem,
                                                 input logic [63:0] carpim,
                                                 input logic [31:0] islec0,
                                                 input logic [31:0] islec1);
      logic [31:0] ust;
      logic [31:0] ek0;
      logic [31:0] ek1;
      logic [31:0] sonuc;
      ust   = carpim[63:32];
      ek0   = islec0[31] ? islec1 : 32'd0;
      ek1   = islec1[31] ? islec0 : 32'd0;
      sonuc = carpim[31:0];
      case (islem)
         ISLEM_MUL:    sonuc = carpim[31:0];
         ISLEM_MULH:   sonuc = ust;
         ISLEM_MULHSU: sonuc = ust + ek1;
         ISLEM_MULHU:  sonuc = ust + ek0 + ek1;
      endcase
      return sonuc;
   endfunction

endpackage

// File: rtl/carpici_pipe3.sv
// rtl/carpici_pipe3.sv - non-stalling 32x32 signed multiplier with a fixed 3-cycle latency
module carpici_pipe3 (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        islem_gecerli_i,
   input  logic [31:0] islec0_i,
   input  logic [31:0] islec1_i,
   output logic [63:0] carpim_o,
   output logic        carpim_gecerli_o
);

   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [63:0] carpim_q1;
   logic [63:0] carpim_q2;
   logic [2:0]  gecerli_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         gecerli_q <= 3'b000;
      end else begin
         gecerli_q <= {gecerli_q[1:0], islem_gecerli_i};
      end
   end

   // Data stages run every cycle; only the valid chain is reset.
   always_ff @(posedge clk_i) begin
      a_q       <= islec0_i;
      b_q       <= islec1_i;
      carpim_q1 <= $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
      carpim_q2 <= carpim_q1;
   end

   assign carpim_o         = carpim_q2;
   assign carpim_gecerli_o = gecerli_q[2];

endmodule

// File: rtl/sonuc_fifo.sv
// rtl/sonuc_fifo.sv - first-word-fall-through result FIFO; output data reads as zero while empty
module sonuc_fifo #(
   parameter int DERINLIK = 4,
   parameter int GENISLIK = 37
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                yaz_i,
   input  logic [GENISLIK-1:0] yaz_veri_i,
   input  logic                oku_i,
   output logic                gecerli_o,
   output logic [GENISLIK-1:0] veri_o
);

   localparam int AW = $clog2(DERINLIK);

   logic [GENISLIK-1:0] bellek [DERINLIK];
   logic [AW:0]         yaz_isaret;
   logic [AW:0]         oku_isaret;
   logic                bos;
   logic                dolu;
   logic                yaz_etkin;
   logic                oku_etkin;

   // Extra pointer bit tells full from empty when the indices meet.
   assign bos       = (yaz_isaret == oku_isaret);
   assign dolu      = (yaz_isaret[AW] != oku_isaret[AW]) &&
                      (yaz_isaret[AW-1:0] == oku_isaret[AW-1:0]);
   assign yaz_etkin = yaz_i && !dolu;
   assign oku_etkin = oku_i && !bos;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         yaz_isaret <= '0;
         oku_isaret <= '0;
      end else begin
         if (yaz_etkin) begin
            yaz_isaret <= yaz_isaret + (AW+1)'(1);
         end
         if (oku_etkin) begin
            oku_isaret <= oku_isaret + (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (yaz_etkin) begin
         bellek[yaz_isaret[AW-1:0]] <= yaz_veri_i;
      end
   end

   assign gecerli_o = !bos;
   assign veri_o    = bos ? '0 : bellek[oku_isaret[AW-1:0]];

endmodule

// File: rtl/carpma_birimi.sv
// rtl/carpma_birimi.sv - credit-controlled RISC-V MUL/MULH* unit around carpici_pipe3 and sonuc_fifo
// Optional MUL_REUSE_EN: single-entry operand/product cache that answers repeats in one cycle.
module carpma_birimi import carpma_pkg::*; (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       istek_gecerli_i,
   output logic                       istek_hazir_o,
   input  logic [1:0]                 islem_i,
   input  logic [31:0]                islec0_i,
   input  logic [31:0]                islec1_i,
   input  logic [ETIKET_GENISLIK-1:0] etiket_i,
   output logic                       sonuc_gecerli_o,
   input  logic                       sonuc_hazir_i,
   output logic [31:0]                sonuc_o,
   output logic [ETIKET_GENISLIK-1:0] sonuc_etiket_o
);

   localparam int SON = CARPICI_GECIKME - 1;

   logic [SAYAC_GENISLIK-1:0] ucus_sayisi;
   logic                      kabul;
   logic                      cikis;
   logic                      isabet;
   golge_t                    golge [CARPICI_GECIKME];
   logic [63:0]               carpim;
   logic                      unused_carpim_gecerli;
   logic                      fifo_yaz;
   logic [KAYIT_GENISLIK-1:0] fifo_yaz_veri;
   logic [KAYIT_GENISLIK-1:0] fifo_veri;

   // Credits cover in-flight plus buffered results, so the FIFO cannot overflow.
   assign istek_hazir_o = (ucus_sayisi < SAYAC_GENISLIK'(FIFO_DERINLIK)) && rst_ni;
   assign kabul         = istek_gecerli_i && istek_hazir_o;
   assign cikis         = sonuc_gecerli_o && sonuc_hazir_i;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ucus_sayisi <= '0;
      end else if (kabul && !cikis) begin
         ucus_sayisi <= ucus_sayisi + SAYAC_GENISLIK'(1);
      end else if (!kabul && cikis) begin
         ucus_sayisi <= ucus_sayisi - SAYAC_GENISLIK'(1);
      end
   end

   carpici_pipe3 u_carpici (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .islem_gecerli_i  (kabul && !isabet),
      .islec0_i         (islec0_i),
      .islec1_i         (islec1_i),
      .carpim_o         (carpim),
      .carpim_gecerli_o (unused_carpim_gecerli)
   );

   // Shadow pipe is the sole authority on retirement; payload flows freely.
   always_ff @(posedge clk_i) begin
      golge[0] <= '{gecerli: kabul && !isabet,
                    islem:   islem_t'(islem_i),
                    etiket:  etiket_i,
                    islec0:  islec0_i,
                    islec1:  islec1_i};
      for (int i = 1; i < CARPICI_GECIKME; i++) begin
         golge[i] <= golge[i-1];
      end
      if (!rst_ni) begin
         for (int i = 0; i < CARPICI_GECIKME; i++) begin
            golge[i].gecerli <= 1'b0;
         end
      end
   end

`ifdef MUL_REUSE_EN
   logic        onbellek_gecerli;
   logic [31:0] onbellek_islec0;
   logic [31:0] onbellek_islec1;
   logic [63:0] onbellek_carpim;
   logic        golge_dolu;

   always_comb begin
      golge_dolu = 1'b0;
      for (int i = 0; i < CARPICI_GECIKME; i++) begin
         golge_dolu = golge_dolu | golge[i].gecerli;
      end
   end

   // An empty shadow pipe guarantees a hit cannot overtake an older result.
   assign isabet = onbellek_gecerli && !golge_dolu &&
                   (islec0_i == onbellek_islec0) && (islec1_i == onbellek_islec1);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         onbellek_gecerli <= 1'b0;
      end else if (golge[SON].gecerli) begin
         onbellek_gecerli <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (golge[SON].gecerli) begin
         onbellek_islec0 <= golge[SON].islec0;
         onbellek_islec1 <= golge[SON].islec1;
         onbellek_carpim <= carpim;
      end
   end
`else
   assign isabet = 1'b0;
`endif

   always_comb begin
      fifo_yaz      = golge[SON].gecerli;
      fifo_yaz_veri = {golge[SON].etiket,
                       sonuc_hesapla(golge[SON].islem, carpim,
                                     golge[SON].islec0, golge[SON].islec1)};
`ifdef MUL_REUSE_EN
      if (kabul && isabet) begin
         fifo_yaz      = 1'b1;
         fifo_yaz_veri = {etiket_i,
                          sonuc_hesapla(islem_t'(islem_i), onbellek_carpim,
                                        islec0_i, islec1_i)};
      end
`endif
   end

   sonuc_fifo #(
      .DERINLIK (FIFO_DERINLIK),
      .GENISLIK (KAYIT_GENISLIK)
   ) u_sonuc_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .yaz_i      (fifo_yaz),
      .yaz_veri_i (fifo_yaz_veri),
      .oku_i      (sonuc_hazir_i),
      .gecerli_o  (sonuc_gecerli_o),
      .veri_o     (fifo_veri)
   );

   assign sonuc_o        = fifo_veri[31:0];
   assign sonuc_etiket_o = fifo_veri[KAYIT_GENISLIK-1:32];

endmodule
